ncl_sync_injector: RTL and testbench

Clocked-to-NCL boundary stage that feeds the dual-rail threshold-gate pipeline. It accepts single-rail words over a valid/ready handshake and drives them as monotonic DATA/NULL wavefronts on dual-rail outputs. Wavefronts are paced by the downstream completion acknowledge `ncl_ki`. It sits directly upstream of the first TH22/TH34W22 register stage and is the only clocked element on the NCL input side.

---
 rtl/ncl_pkg.sv | 25 ++
 rtl/ncl_sync_bit.sv | 24 ++
 rtl/ncl_sync_injector.sv | 105 ++++++++++
 tb/tb_ncl_sync_injector.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_pkg.sv
// Shared NCL types: dual-rail pair, injector state, handshake levels.
// Used by the clocked injector and the downstream collector.
package ncl_pkg;

    typedef struct packed {
        logic t;
        logic f;
    } dual_rail_t;

    typedef enum logic {
        S_NULL = 1'b0,
        S_DATA = 1'b1
    } inj_state_e;

    localparam logic NCL_RFD = 1'b1;
    localparam logic NCL_RFN = 1'b0;

    function automatic dual_rail_t encode_bit(input logic b);
        dual_rail_t r;
        r.t = b;
        r.f = ~b;
        return r;
    endfunction

endpackage

// File: rtl/ncl_sync_bit.sv
// Multi-flop synchronizer for one asynchronous level, async reset to 0.
// Ports: clk, rst, d (async level in), q (synchronized level out).
module ncl_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ncl_sync_injector.sv
// Clocked-to-NCL boundary: turns valid/ready words into DATA/NULL wavefronts.
// Ports: clk, rst (async high), in_valid/in_ready/in_data (upstream word),
//        ncl_t/ncl_f (registered dual rails), ncl_ki (async ack in),
//        busy (DATA outstanding), word_count (DATA wavefronts, wraps).
module ncl_sync_injector
    import ncl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] ncl_t,
    output logic [WIDTH-1:0] ncl_f,
    input  logic             ncl_ki,
    output logic             busy,
    output logic [15:0]      word_count
);

    inj_state_e              state_q;
    inj_state_e              state_d;
    dual_rail_t [WIDTH-1:0]  rails_q;
    logic [15:0]             count_q;
    logic                    ki_s;
    logic                    load;
    logic                    clear;

    ncl_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ki_sync (
        .clk (clk),
        .rst (rst),
        .d   (ncl_ki),
        .q   (ki_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_NULL;
        end else begin
            state_q <= state_d;
        end
    end

    // in_ready depends only on state and ki_s so upstream can never
    // build a combinational loop through in_valid.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        load     = 1'b0;
        clear    = 1'b0;
        unique case (state_q)
            S_NULL: begin
                in_ready = (ki_s == NCL_RFD);
                if (in_valid && in_ready) begin
                    load    = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (ki_s == NCL_RFN) begin
                    clear   = 1'b1;
                    state_d = S_NULL;
                end
            end
            default: begin
                state_d = S_NULL;
            end
        endcase
    end

    // Rails only ever move NULL->DATA (load) or DATA->NULL (clear or
    // async reset), which keeps every wavefront monotonic downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rails_q <= '0;
        end else if (load) begin
            for (int i = 0; i < WIDTH; i++) begin
                rails_q[i] <= encode_bit(in_data[i]);
            end
        end else if (clear) begin
            rails_q <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= count_q + 16'd1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_rail
        assign ncl_t[g] = rails_q[g].t;
        assign ncl_f[g] = rails_q[g].f;
    end

    assign busy       = (state_q == S_DATA);
    assign word_count = count_q;

endmodule

// File: tb/tb_ncl_sync_injector.sv
// Self-checking bench for ncl_sync_injector: scoreboarded wavefronts,
// rail invariants, ack latencies, backpressure, async reset, counter wrap.
module tb_ncl_sync_injector;

    localparam int W  = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [W-1:0]  ncl_t;
    logic [W-1:0]  ncl_f;
    logic          ncl_ki;
    logic          busy;
    logic [15:0]   word_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [15:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_count;

    ncl_sync_injector #(
        .WIDTH       (W),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .ncl_t      (ncl_t),
        .ncl_f      (ncl_f),
        .ncl_ki     (ncl_ki),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Monitor: invariants every cycle, scoreboard pop on each new DATA.
    logic [W-1:0] pt = '0;
    logic [W-1:0] pf = '0;
    logic         pbusy  = 1'b0;
    logic         pready = 1'b0;

    always @(posedge clk) begin : monitor
        exp_t e;
        #2;
        checks++;
        if ((ncl_t & ncl_f) !== '0) begin
            failures++;
            $display("FAIL rail_excl t=%h f=%h required and=00", ncl_t, ncl_f);
        end
        checks++;
        if (!((((ncl_t & pt) == pt) && ((ncl_f & pf) == pf)) ||
              (((ncl_t & ~pt) == '0) && ((ncl_f & ~pf) == '0)))) begin
            failures++;
            $display("FAIL monotone t %h->%h f %h->%h", pt, ncl_t, pf, ncl_f);
        end
        checks++;
        if (busy && in_ready) begin
            failures++;
            $display("FAIL ready_while_busy in_ready=1 required 0");
        end
        if (busy && !pbusy) begin
            checks++;
            if (!pready) begin
                failures++;
                $display("FAIL accept_gate in_ready_before=0 required 1");
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word t=%h required none", ncl_t);
            end else begin
                e = sb.pop_front();
                if (ncl_t !== e.d || ncl_f !== ~e.d || word_count !== e.cnt) begin
                    failures++;
                    $display("FAIL sb_word t=%h f=%h cnt=%h required t=%h f=%h cnt=%h",
                             ncl_t, ncl_f, word_count, e.d, ~e.d, e.cnt);
                end
            end
        end
        pt     = ncl_t;
        pf     = ncl_f;
        pbusy  = busy;
        pready = in_ready;
    end

    task automatic do_reset(input logic ki);
        rst       = 1'b1;
        ncl_ki    = ki;
        in_valid  = 1'b0;
        in_data   = '0;
        sb.delete();
        exp_count = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int exp_edges);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!in_ready || (exp_edges >= 0 && n != exp_edges)) begin
            failures++;
            $display("FAIL ready_latency edges=%0d ready=%b required edges=%0d ready=1",
                     n, in_ready, exp_edges);
        end
    endtask

    task automatic inject(input logic [W-1:0] d);
        bit ok;
        exp_count = exp_count + 16'd1;
        sb.push_back('{d: d, cnt: exp_count});
        in_data  = d;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout busy=0 required 1 data=%h", d);
        end
    endtask

    task automatic retire(input int rfn_delay);
        int n;
        repeat (rfn_delay) @(posedge clk);
        #1;
        ncl_ki = 1'b0;
        n = 0;
        while ((ncl_t != '0 || ncl_f != '0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != SS + 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL null_latency edges=%0d busy=%b required edges=%0d busy=0",
                     n, busy, SS + 1);
        end
        repeat (3) @(posedge clk);
        #1;
        ncl_ki = 1'b1;
        wait_ready(SS);
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        ncl_ki   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        sb.delete();
        exp_count = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ncl_t !== '0 || ncl_f !== '0 || in_ready !== 1'b0 ||
            busy !== 1'b0 || word_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs t=%h f=%h rdy=%b busy=%b cnt=%h required all 0",
                     ncl_t, ncl_f, in_ready, busy, word_count);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_edge1 in_ready=%b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_edge2 in_ready=%b required 1", in_ready);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ncl_t !== '0 || ncl_f !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_rails t=%h f=%h busy=%b required 0 0 0", ncl_t, ncl_f, busy);
        end
    endtask

    task automatic test_single_word;
        inject(8'hA5);
        checks++;
        if (ncl_t !== 8'hA5 || ncl_f !== 8'h5A || word_count !== 16'd1) begin
            failures++;
            $display("FAIL single_word t=%h f=%h cnt=%h required A5 5A 0001",
                     ncl_t, ncl_f, word_count);
        end
        retire(3);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] w [3];
        int           acc;
        logic         pb;
        w[0] = 8'h00;
        w[1] = 8'hFF;
        w[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            exp_count = exp_count + 16'd1;
            sb.push_back('{d: w[i], cnt: exp_count});
        end
        acc      = 0;
        pb       = busy;
        in_data  = w[0];
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (busy && !pb) begin
                acc++;
                if (acc < 3) in_data = w[acc];
                else in_valid = 1'b0;
            end
            if (busy && ncl_ki) begin
                ncl_ki = 1'b0;
            end else if (!busy && !ncl_ki && ncl_t == '0 && ncl_f == '0) begin
                ncl_ki = 1'b1;
            end
            pb = busy;
            if (acc == 3 && in_ready) break;
        end
        in_valid = 1'b0;
        checks++;
        if (acc != 3 || sb.size() != 0 || !in_ready) begin
            failures++;
            $display("FAIL b2b_stream accepted=%0d pending=%0d rdy=%b required 3 0 1",
                     acc, sb.size(), in_ready);
        end
    endtask

    task automatic test_backpressure;
        int  n;
        bit  held;
        do_reset(1'b0);
        exp_count = exp_count + 16'd1;
        sb.push_back('{d: 8'h11, cnt: exp_count});
        in_data  = 8'h11;
        in_valid = 1'b1;
        held = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (in_ready !== 1'b0 || ncl_t !== '0 || ncl_f !== '0) held = 1'b0;
        end
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL backpressure_hold rdy=%b t=%h required 0 00", in_ready, ncl_t);
        end
        ncl_ki = 1'b1;
        n = 0;
        while (ncl_t !== 8'h11 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (ncl_t !== 8'h11 || n != SS + 1) begin
            failures++;
            $display("FAIL backpressure_release edges=%0d t=%h required edges=%0d t=11",
                     n, ncl_t, SS + 1);
        end
        retire(1);
    endtask

    task automatic test_reset_mid_data;
        inject(8'hA5);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (ncl_t !== '0 || ncl_f !== '0 || word_count !== 16'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset t=%h f=%h cnt=%h busy=%b required 0",
                     ncl_t, ncl_f, word_count, busy);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_count = '0;
        wait_ready(SS);
        inject(8'h3C);
        checks++;
        if (ncl_t !== 8'h3C || word_count !== 16'd1) begin
            failures++;
            $display("FAIL post_reset_word t=%h cnt=%h required 3C 0001", ncl_t, word_count);
        end
        retire(3);
    endtask

    task automatic test_counter_wrap;
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        exp_count = 16'hFFFF;
        inject(8'h77);
        checks++;
        if (word_count !== 16'h0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL counter_wrap cnt=%h busy=%b required 0000 1", word_count, busy);
        end
        retire(2);
    endtask

    initial begin
        rst      = 1'b1;
        ncl_ki   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_data();
        test_counter_wrap();
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain pending=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
